wb_hk_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter sharing the housekeeping Wishbone slave port between the management core (master 0) and a UART/debug bridge (master 1).
- Sits between the management core's housekeeping strobe/cycle outputs, the bridge, and the housekeeping wb_* slave inputs.
- Grants are locked for the whole cycle (cyc) of the granted master.
- Arbitration is round-robin or fixed-priority; an optional bus timeout is available.

---
 rtl/wb_hk_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_hk_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_hk_arbiter.sv
`default_nettype none
//============================================================================
// Module : wb_hk_arbiter
// Two-master Wishbone arbiter for the housekeeping slave port, with a grant
// locked for the whole cycle. Bus timeout enabled by WB_HK_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
//============================================================================
module wb_hk_arbiter #(
   parameter int PRIORITY_MODE  = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic        w_last_nxt;
   logic        w_req0;
   logic        w_req1;
   logic        w_g0;
   logic        w_g1;
   logic        w_cyc;
   logic        w_stb;
   logic        w_we;
   logic [3:0]  w_sel;
   logic [31:0] w_adr;
   logic [31:0] w_dat;
   logic        w_tmo;
   logic        w_ack;

   if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
      $error("wb_hk_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   assign w_req0 = m0_cyc_i & m0_stb_i;
   assign w_req1 = m1_cyc_i & m1_stb_i;

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Releasing always passes through IDLE, giving one turnaround cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_req0 && w_req1)
               w_state_nxt = ((PRIORITY_MODE != 0) || r_last) ? GNT0 : GNT1;
            else if (w_req0)
               w_state_nxt = GNT0;
            else if (w_req1)
               w_state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               w_state_nxt = IDLE;
               w_last_nxt  = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               w_state_nxt = IDLE;
               w_last_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_g0 = (r_state == GNT0);
   assign w_g1 = (r_state == GNT1);

   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_sel = '0;
      w_adr = '0;
      w_dat = '0;
      if (w_g0) begin
         w_cyc = m0_cyc_i;
         w_stb = m0_stb_i;
         w_we  = m0_we_i;
         w_sel = m0_sel_i;
         w_adr = m0_adr_i;
         w_dat = m0_dat_i;
      end else if (w_g1) begin
         w_cyc = m1_cyc_i;
         w_stb = m1_stb_i;
         w_we  = m1_we_i;
         w_sel = m1_sel_i;
         w_adr = m1_adr_i;
         w_dat = m1_dat_i;
      end
   end

`ifdef WB_HK_ARB_TIMEOUT_EN
   localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TMO_W-1:0] r_tmo_cnt;

   // An ack in the expiry cycle wins, so expiry requires no ack.
   assign w_tmo = w_stb & ~s_ack_i & (r_tmo_cnt == c_TMO_LAST);

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i)
         r_tmo_cnt <= '0;
      else if ((r_state == IDLE) || s_ack_i || !s_stb_o)
         r_tmo_cnt <= '0;
      else
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end
`else
   assign w_tmo = 1'b0;
`endif

   assign s_cyc_o = w_cyc;
   assign s_stb_o = w_stb & ~w_tmo;
   assign s_we_o  = w_we;
   assign s_sel_o = w_sel;
   assign s_adr_o = w_adr;
   assign s_dat_o = w_dat;

   // Gating with s_stb_o drops late acks from an aborted cycle.
   assign w_ack = s_ack_i & s_stb_o;

   assign m0_ack_o = w_g0 & w_ack;
   assign m0_err_o = w_g0 & w_tmo;
   assign m0_dat_o = w_g0 ? s_dat_i : '0;
   assign m1_ack_o = w_g1 & w_ack;
   assign m1_err_o = w_g1 & w_tmo;
   assign m1_dat_o = w_g1 ? s_dat_i : '0;

   assign grant_o = {w_g1, w_g0};
   assign busy_o  = w_g0 | w_g1;

endmodule
`default_nettype wire

// File: tb/tb_wb_hk_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_wb_hk_arbiter
// Scoreboard bench for wb_hk_arbiter with a cycle-level reference model.
// Rev    : 1.0  initial release
//============================================================================
module tb_wb_hk_arbiter;

   localparam int          PRIO = 0;
   localparam int          TMO  = 8;
   localparam logic [31:0] K    = 32'h83A5_0005;  // slave read data = adr ^ K

   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
   } beat_t;

   logic clk, rstn;
   logic [1:0] mcyc, mstb, mwe;
   logic [1:0][3:0]  msel;
   logic [1:0][31:0] madr, mdat;
   logic m0_ack, m1_ack, m0_err, m1_err;
   logic [31:0] m0_dato, m1_dato;
   logic [1:0] mack, merr;
   logic [1:0][31:0] mdato;
   logic s_cyc, s_stb, s_we, s_ack;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dato, s_dati;
   logic [1:0]  grant;
   logic        busy;
   logic        sl_ack, sl_nxt, force_ack, slave_on;
   int          slave_lat, wcnt, lat;

   int total = 0;
   int bad   = 0;
   beat_t q0[$];
   beat_t q1[$];

   assign mack   = {m1_ack, m0_ack};
   assign merr   = {m1_err, m0_err};
   assign mdato  = {m1_dato, m0_dato};
   assign s_ack  = sl_ack | force_ack;
   assign s_dati = s_adr ^ K;

   wb_hk_arbiter #(.PRIORITY_MODE(PRIO), .TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk_i(clk), .wb_rstn_i(rstn),
      .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
      .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
      .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_dato),
      .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
      .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
      .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_dato),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_adr_o(s_adr), .s_dat_o(s_dato), .s_ack_i(s_ack), .s_dat_i(s_dati),
      .grant_o(grant), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // ---------------- slave model: acks lat cycles after stb is seen ----------
   initial begin
      sl_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1 sl_ack = sl_nxt;
      end
   end

   always @(negedge clk) begin
      if (!rstn || !slave_on || !s_stb || s_ack) begin
         wcnt   = 0;
         sl_nxt = 1'b0;
         lat    = (slave_lat > 0) ? slave_lat : 1 + int'($urandom % 4);
      end else begin
         wcnt++;
         if (wcnt >= lat) sl_nxt = 1'b1;
      end
   end

   // ---------------- reference model + monitor + scoreboard -----------------
   int owner    = -1;   // master holding the bus this cycle, -1 = none
   int last_srv = 1;
   int tcnt     = 0;    // cycles the owner's strobe has waited without ack

   always @(negedge clk) begin : mon
      logic        exp_err;
      logic [1:0]  eg;
      logic [70:0] es;
      logic [1:0]  req;
      beat_t       b;
      int          sz;
      if (!rstn) begin
         chk("rst_outputs", {grant, busy, mack, merr, mdato, s_cyc, s_stb, s_we,
                             s_sel, s_adr, s_dato}, '0);
         owner = -1; last_srv = 1; tcnt = 0;
      end else begin
         exp_err = 1'b0;
`ifdef WB_HK_ARB_TIMEOUT_EN
         if (owner >= 0) exp_err = mstb[owner] && !s_ack && (tcnt == TMO - 1);
`endif
         eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
         chk("grant", grant, eg);
         chk("busy", busy, owner >= 0);
         es = '0;
         if (owner >= 0)
            es = {mcyc[owner], mstb[owner] & ~exp_err, mwe[owner], msel[owner],
                  madr[owner], mdat[owner]};
         chk("s_bus", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dato}, es);
         for (int m = 0; m < 2; m++)
            chk(m == 0 ? "m0_resp" : "m1_resp", {mack[m], merr[m], mdato[m]},
                (m == owner) ? {s_ack & mstb[m], exp_err, s_dati} : 34'b0);

         for (int m = 0; m < 2; m++) begin
            if (mack[m] | merr[m]) begin
               sz = (m == 0) ? q0.size() : q1.size();
               chk("sb_pop", sz > 0, 1'b1);
               if (sz > 0) begin
                  b = (m == 0) ? q0.pop_front() : q1.pop_front();
                  chk("sb_adr", s_adr, b.adr);
                  chk("sb_ctl", {s_we, s_sel}, {b.we, b.sel});
                  if (b.we) chk("sb_wdat", s_dato, b.dat);
                  if (mack[m] && !b.we) chk("sb_rdat", mdato[m], b.adr ^ K);
               end
            end
         end

`ifdef WB_HK_ARB_TIMEOUT_EN
         if (owner >= 0 && mstb[owner] && !exp_err && !s_ack) tcnt++;
         else tcnt = 0;
`endif
         req = mcyc & mstb;
         if (owner < 0) begin
            if (req == 2'b11)  owner = (PRIO != 0) ? 0 : 1 - last_srv;
            else if (req[0])   owner = 0;
            else if (req[1])   owner = 1;
         end else if (!mcyc[owner]) begin
            last_srv = owner;
            owner    = -1;
         end
      end
   end

   // ---------------- master drivers -----------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_cycle(input int m, input int nb, input int wem, input int gap,
                           input logic [31:0] adr0);
      beat_t b;
      int    n;
      mcyc[m] = 1'b1;
      for (int i = 0; i < nb; i++) begin
         b.adr = adr0 + 32'(4 * i);
         b.we  = (wem == 2) ? 1'($urandom % 2) : (wem == 1);
         b.sel = 4'($urandom);
         b.dat = $urandom;
         mwe[m] = b.we; msel[m] = b.sel; madr[m] = b.adr; mdat[m] = b.dat;
         mstb[m] = 1'b1;
         if (m == 0) q0.push_back(b);
         else        q1.push_back(b);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(mack[m] | merr[m]) && n < 200);
         if (!(mack[m] | merr[m])) chk("m_wait", mack[m] | merr[m], 1'b1);
         idle(1);
         if (gap != 0 && i < nb - 1) begin
            mstb[m] = 1'b0;
            idle(1);
         end
      end
      mcyc[m] = 1'b0;
      mstb[m] = 1'b0;
      idle(1);
   endtask

   task automatic set_m0(input logic [31:0] adr);
      beat_t b;
      b = '{adr: adr, we: 1'b0, sel: 4'hF, dat: 32'h0};
      madr[0] = adr; msel[0] = 4'hF; mwe[0] = 1'b0; mdat[0] = '0;
      mcyc[0] = 1'b1; mstb[0] = 1'b1;
      q0.push_back(b);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int n, c0, nerr, eidx;
      rstn = 1'b0; mcyc = '0; mstb = '0; mwe = '0; msel = '0; madr = '0; mdat = '0;
      force_ack = 1'b0; slave_on = 1'b1; slave_lat = 0; sl_nxt = 1'b0;
      idle(3);
      rstn = 1'b1;
      idle(2);

      // round robin: both masters re-request continuously, m0 first
      fork
         repeat (4) do_cycle(0, 1, 2, 0, {$urandom} & 32'hFFFF_FFFC);
         repeat (4) do_cycle(1, 1, 2, 0, {$urandom} & 32'hFFFF_FFFC);
         begin
            n = 0;
            do begin @(negedge clk); n++; end while (grant == 2'b00 && n < 20);
            chk("rr_first", grant, 2'b01);
         end
      join
      idle(2);

      // single read, slave acks two cycles after the strobe
      slave_lat = 2;
      do_cycle(0, 1, 0, 0, 32'h2600_0004);
      slave_lat = 0;
      idle(2);

      // lock: m1 holds cyc across 3 beats with stb toggling while m0 waits
      fork
         do_cycle(1, 3, 2, 1, 32'h2600_0100);
         begin idle(2); do_cycle(0, 1, 2, 0, 32'h2600_0200); end
      join
      idle(2);

      // random traffic
      fork
         for (int i = 0; i < 12; i++) begin
            idle($urandom % 3);
            do_cycle(0, 1 + $urandom % 3, 2, $urandom % 2, {$urandom} & 32'hFFFF_FFFC);
         end
         for (int i = 0; i < 12; i++) begin
            idle($urandom % 3);
            do_cycle(1, 1 + $urandom % 3, 2, $urandom % 2, {$urandom} & 32'hFFFF_FFFC);
         end
      join
      idle(3);

      // abort: m0 drops cyc before ack, a late ack lands in IDLE
      slave_on = 1'b0;
      madr[0] = 32'h2600_0300; mcyc[0] = 1'b1; mstb[0] = 1'b1;
      idle(3);
      mcyc[0] = 1'b0; mstb[0] = 1'b0;
      idle(1);
      force_ack = 1'b1;
      @(negedge clk);
      chk("abort_ack", mack, 2'b00);
      chk("abort_grant", grant, 2'b00);
      idle(1);
      force_ack = 1'b0;
      idle(2);

      // timeout: slave never acks
      madr[0] = 32'h2600_0400; msel[0] = 4'hF; mwe[0] = 1'b0;
      mcyc[0] = 1'b1; mstb[0] = 1'b1;
`ifdef WB_HK_ARB_TIMEOUT_EN
      q0.push_back('{adr: 32'h2600_0400, we: 1'b0, sel: 4'hF, dat: mdat[0]});
`endif
      c0 = -1; nerr = 0; eidx = -1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c0 < 0 && s_stb) c0 = c;
         if (merr[0]) begin nerr++; eidx = c - c0; end
      end
`ifdef WB_HK_ARB_TIMEOUT_EN
      chk("tmo_count", nerr, 1);
      chk("tmo_cycle", eidx, 7);   // error in the eighth cycle of strobe
`else
      chk("tmo_none", nerr, 0);
      chk("tmo_held", grant, 2'b01);
`endif
      idle(1);
      mcyc[0] = 1'b0; mstb[0] = 1'b0;
      idle(3);

      // asynchronous reset mid-grant with ack asserted
      set_m0(32'h2600_0500);
      idle(2);
      force_ack = 1'b1;
      @(posedge clk);
      #3 rstn = 1'b0;
      #1 chk("rst_async", {grant, busy, mack, merr, mdato, s_cyc, s_stb, s_we,
                           s_sel, s_adr, s_dato}, '0);
      @(posedge clk);
      #1 force_ack = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_idle", grant, 2'b00);
      idle(2);
      mcyc[0] = 1'b0; mstb[0] = 1'b0;
      slave_on = 1'b1;
      idle(4);

      chk("sb_drain", q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
